gpio_control_bank: RTL and testbench
====================================

// Module: gpio_control_bank
// PURPOSE
//  - Parametrised multi-channel successor to the single-pad GPIO control cell; sits in the padframe ring.
//  - One instance serves NUM_GPIO pads from a single serial configuration chain.
//  - Adds a bit counter with frame-length checking, per-channel load enables, a sticky error flag
//    and an optional per-channel parity check.
//  - Fully synchronous to serial_clock; serial_load is treated as sampled data, not as a clock.
// PARAMETERS
//  NUM_GPIO       4                  number of pad channels in the bank (1..32)
//  PAD_CTRL_BITS  16                 config bits per channel (>=16); bits [PAD_CTRL_BITS-1:16] shift through but are not stored
//  GPIO_DEFAULTS  {NUM_GPIO{16'h3000}}  NUM_GPIO*16 reset config; channel ch = GPIO_DEFAULTS[ch*16 +: 16]
// PORTS
//  serial_clock      in   1      sole clock; all flops on rising edge
//  reset             in   1      synchronous, active-high; wins over every other input in the same cycle
//  serial_shift_en   in   1      qualifies serial_data_in: one bit is shifted per cycle while high
//  serial_data_in    in   1      chain input
//  serial_data_out   out  1      chain output = MSB flop of chain (feeds the next bank)
//  serial_load       in   1      load request; acted on at its sampled rising edge
//  frame_err_clr     in   1      clears frame_err (and parity_err)
//  cfg_loaded        out  1      1-cycle pulse on a successful load
//  frame_err         out  1      sticky: load attempted with a wrong bit count
//  user_gpio_out     in   N      user-to-pad data, one bit per channel
//  user_gpio_oeb     in   N      user output enable, active-low
//  user_gpio_in      out  N      = pad_gpio_in (combinational)
//  pad_gpio_in       in   N      pad-to-core data
//  pad_gpio_out      out  N      ch: mgmt_en ? mgmt_out : user_gpio_out[ch]
//  pad_gpio_outenb   out  N      ch: mgmt_en ? mgmt_oeb : user_gpio_oeb[ch]
//  pad_gpio_cfg      out  12*N   ch slice [ch*12 +: 12] = {dm[2:0],trip,slow,an_pol,an_sel,an_en,mod_sel,inp_dis,hldh,rsvd0}
//  (N = NUM_GPIO)
// BEHAVIOUR
//  - Frame geometry
//    - FRAME_W = PAD_CTRL_BITS (+1 when parity is enabled); chain length L = NUM_GPIO*FRAME_W.
//    - Channel ch occupies chain[ch*FRAME_W +: FRAME_W], so the first bits shifted land in the highest channel.
//  - Field layout (frame bit offsets)
//    - 0 mgmt_en, 1 mgmt_oeb, 2 mgmt_out, 3 hldh, 4 inp_dis, 5 mod_sel, 6 an_en, 7 an_sel, 8 an_pol.
//    - 9 slow, 10 trip, 11 rsvd, 14:12 dm, 15 ld_enb.
//  - Shift: when serial_shift_en=1, chain <= {chain[L-2:0], serial_data_in}.
//  - Bit counter bit_cnt: +1 per shifted bit, saturating at L+1. States decoded from it:
//    - IDLE: cnt=0.
//    - FILL: 0<cnt<L.
//    - FULL: cnt=L.
//    - OVER: cnt=L+1.
//  - Load: ld_edge = serial_load & ~serial_load_q (serial_load_q registered). When ld_edge fires:
//    - FULL: every channel with ld_enb=1 (and parity OK) latches its fields one cycle later;
//      channels with ld_enb=0 keep their config.
//    - FULL: cfg_loaded pulses in the same cycle the fields update.
//    - Not FULL: no channel latches, cfg_loaded stays 0, frame_err <= 1.
//    - In both cases bit_cnt is cleared; the chain contents are kept.
//  - Shift and ld_edge in the same cycle:
//    - The load uses the chain value from before this cycle's shift.
//    - bit_cnt becomes 1.
//  - frame_err_clr together with a new error in the same cycle: the error wins, flag stays 1.
//  - serial_load held high produces exactly one load; it must return low before the next one.
//  - Reset values:
//    - chain, bit_cnt, serial_load_q, cfg_loaded, frame_err, parity_err = 0.
//    - Per-channel latched config = GPIO_DEFAULTS.
//    - serial_data_out = 0.
//  - Reset mid-shift or mid-load aborts; no partial latch occurs.
//  - pad_gpio_out, pad_gpio_outenb and user_gpio_in are combinational from the latched config and
//    the inputs; no added latency.
// CONFIGURATION
//  GPIO_CTRL_PARITY_EN defined:
//    - FRAME_W = PAD_CTRL_BITS+1; bit PAD_CTRL_BITS is even parity over the channel's PAD_CTRL_BITS data bits.
//    - A mismatching channel is not latched; the other channels still latch.
//    - Output parity_err (1 bit, sticky) is set; it is cleared by frame_err_clr.
//    - cfg_loaded pulses only if no channel in the frame mismatched.
//  GPIO_CTRL_PARITY_EN undefined:
//    - FRAME_W = PAD_CTRL_BITS; no parity_err port; no check.
// TESTING (NUM_GPIO=2, PAD_CTRL_BITS=16, parity off unless stated)
//  1. Reset -> pad_gpio_cfg per channel = defaults (dm=3'b011), pad_gpio_outenb=user_gpio_oeb, frame_err=0.
//  2. Shift ch1=16'h8007, ch0=16'h8001 (32 bits), pulse load
//     -> ch1: mgmt_en=1, pad_gpio_out[1]=1, pad_gpio_outenb[1]=1.
//     -> ch0: pad_gpio_outenb[0]=0; cfg_loaded pulses once.
//  3. Shift 31 bits and load -> no config change, frame_err=1. Shift 33 bits and load -> same result.
//     frame_err_clr -> frame_err=0.
//  4. ch1=16'h0007 (ld_enb=0), ch0=16'h8001 -> only ch0 updates, ch1 keeps its previous config.
//  5. Last bit shifted in the same cycle as the ld_edge -> load rejected as FILL, frame_err=1, bit_cnt=1.
//     Reset asserted during shifting -> all defaults restored.
//  6. PARITY_EN: ch0 parity bit wrong -> ch0 unchanged, ch1 loads, parity_err=1, no cfg_loaded pulse.

Source files
------------

// File: rtl/gpio_control_bank.sv
// Multi-channel GPIO pad control bank loaded from one serial configuration chain.
// Optional per-channel even parity check is enabled by defining GPIO_CTRL_PARITY_EN.
module gpio_control_bank #(
    parameter int                      NUM_GPIO      = 4,
    parameter int                      PAD_CTRL_BITS = 16,
    parameter logic [NUM_GPIO*16-1:0]  GPIO_DEFAULTS = {NUM_GPIO{16'h3000}}
) (
    input  logic                     serial_clock,
    input  logic                     reset,
    input  logic                     serial_shift_en,
    input  logic                     serial_data_in,
    output logic                     serial_data_out,
    input  logic                     serial_load,
    input  logic                     frame_err_clr,
    output logic                     cfg_loaded,
    output logic                     frame_err,
`ifdef GPIO_CTRL_PARITY_EN
    output logic                     parity_err,
`endif
    input  logic [NUM_GPIO-1:0]      user_gpio_out,
    input  logic [NUM_GPIO-1:0]      user_gpio_oeb,
    output logic [NUM_GPIO-1:0]      user_gpio_in,
    input  logic [NUM_GPIO-1:0]      pad_gpio_in,
    output logic [NUM_GPIO-1:0]      pad_gpio_out,
    output logic [NUM_GPIO-1:0]      pad_gpio_outenb,
    output logic [12*NUM_GPIO-1:0]   pad_gpio_cfg,
    output logic [1:0]               frame_state
);

`ifdef GPIO_CTRL_PARITY_EN
    localparam int FRAME_W = PAD_CTRL_BITS + 1;
`else
    localparam int FRAME_W = PAD_CTRL_BITS;
`endif
    localparam int CHAIN_L = NUM_GPIO * FRAME_W;
    localparam int CNT_W   = $clog2(CHAIN_L + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2,
        ST_OVER = 2'd3
    } frame_state_t;

    logic [CHAIN_L-1:0]  chain;
    logic [CNT_W-1:0]    bit_cnt;
    logic                serial_load_q;
    logic [14:0]         cfg_q [NUM_GPIO];
    logic                ld_edge;
    frame_state_t        state;
    logic [NUM_GPIO-1:0] ch_par_ok;
    logic [NUM_GPIO-1:0] ch_latch;
    logic                all_par_ok;

    assign ld_edge         = serial_load & ~serial_load_q;
    assign serial_data_out = chain[CHAIN_L-1];
    assign user_gpio_in    = pad_gpio_in;
    assign frame_state     = state;
    assign all_par_ok      = &ch_par_ok;

    always_comb begin
        state = ST_FILL;
        if (bit_cnt == '0)
            state = ST_IDLE;
        else if (bit_cnt == CNT_W'(CHAIN_L))
            state = ST_FULL;
        else if (bit_cnt == CNT_W'(CHAIN_L + 1))
            state = ST_OVER;
    end

    // A channel latches only when its ld_enb bit is set and its frame is intact.
    always_comb begin
        ch_par_ok = '1;
        ch_latch  = '0;
        for (int ch = 0; ch < NUM_GPIO; ch++) begin
`ifdef GPIO_CTRL_PARITY_EN
            ch_par_ok[ch] = ~^chain[ch*FRAME_W +: FRAME_W];
`endif
            ch_latch[ch] = chain[ch*FRAME_W + 15] & ch_par_ok[ch];
        end
    end

    always_ff @(posedge serial_clock) begin
        if (reset) begin
            chain         <= '0;
            bit_cnt       <= '0;
            serial_load_q <= 1'b0;
            cfg_loaded    <= 1'b0;
            frame_err     <= 1'b0;
`ifdef GPIO_CTRL_PARITY_EN
            parity_err    <= 1'b0;
`endif
            for (int ch = 0; ch < NUM_GPIO; ch++)
                cfg_q[ch] <= GPIO_DEFAULTS[ch*16 +: 15];
        end else begin
            serial_load_q <= serial_load;
            cfg_loaded    <= 1'b0;

            if (serial_shift_en)
                chain <= {chain[CHAIN_L-2:0], serial_data_in};

            // A load restarts counting; a bit shifted in that same cycle is the first of the next frame.
            if (ld_edge)
                bit_cnt <= serial_shift_en ? CNT_W'(1) : '0;
            else if (serial_shift_en && state != ST_OVER)
                bit_cnt <= bit_cnt + 1'b1;

            if (ld_edge && state == ST_FULL) begin
                for (int ch = 0; ch < NUM_GPIO; ch++)
                    if (ch_latch[ch])
                        cfg_q[ch] <= chain[ch*FRAME_W +: 15];
                cfg_loaded <= all_par_ok;
            end

            if (ld_edge && state != ST_FULL)
                frame_err <= 1'b1;
            else if (frame_err_clr)
                frame_err <= 1'b0;

`ifdef GPIO_CTRL_PARITY_EN
            if (ld_edge && state == ST_FULL && !all_par_ok)
                parity_err <= 1'b1;
            else if (frame_err_clr)
                parity_err <= 1'b0;
`endif
        end
    end

    always_comb begin
        pad_gpio_out    = '0;
        pad_gpio_outenb = '0;
        pad_gpio_cfg    = '0;
        for (int ch = 0; ch < NUM_GPIO; ch++) begin
            pad_gpio_out[ch]    = cfg_q[ch][0] ? cfg_q[ch][2] : user_gpio_out[ch];
            pad_gpio_outenb[ch] = cfg_q[ch][0] ? cfg_q[ch][1] : user_gpio_oeb[ch];
            pad_gpio_cfg[ch*12 +: 12] = {cfg_q[ch][14:12], cfg_q[ch][10], cfg_q[ch][9],
                                         cfg_q[ch][8], cfg_q[ch][7], cfg_q[ch][6],
                                         cfg_q[ch][5], cfg_q[ch][4], cfg_q[ch][3],
                                         cfg_q[ch][11]};
        end
    end

endmodule

// File: tb/tb_gpio_control_bank.sv
// Directed bench for gpio_control_bank with two channels of 16 config bits.
module tb_gpio_control_bank;

`ifdef GPIO_CTRL_PARITY_EN
    localparam int FW = 17;
`else
    localparam int FW = 16;
`endif
    localparam int L = 2 * FW;

    logic        serial_clock = 1'b0;
    logic        reset = 1'b1;
    logic        serial_shift_en = 1'b0;
    logic        serial_data_in = 1'b0;
    logic        serial_data_out;
    logic        serial_load = 1'b0;
    logic        frame_err_clr = 1'b0;
    logic        cfg_loaded;
    logic        frame_err;
`ifdef GPIO_CTRL_PARITY_EN
    logic        parity_err;
`endif
    logic [1:0]  user_gpio_out = 2'b01;
    logic [1:0]  user_gpio_oeb = 2'b10;
    logic [1:0]  user_gpio_in;
    logic [1:0]  pad_gpio_in = 2'b10;
    logic [1:0]  pad_gpio_out;
    logic [1:0]  pad_gpio_outenb;
    logic [23:0] pad_gpio_cfg;
    logic [1:0]  frame_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;

    gpio_control_bank #(
        .NUM_GPIO      (2),
        .PAD_CTRL_BITS (16),
        .GPIO_DEFAULTS ({2{16'h3000}})
    ) dut (
        .serial_clock    (serial_clock),
        .reset           (reset),
        .serial_shift_en (serial_shift_en),
        .serial_data_in  (serial_data_in),
        .serial_data_out (serial_data_out),
        .serial_load     (serial_load),
        .frame_err_clr   (frame_err_clr),
        .cfg_loaded      (cfg_loaded),
        .frame_err       (frame_err),
`ifdef GPIO_CTRL_PARITY_EN
        .parity_err      (parity_err),
`endif
        .user_gpio_out   (user_gpio_out),
        .user_gpio_oeb   (user_gpio_oeb),
        .user_gpio_in    (user_gpio_in),
        .pad_gpio_in     (pad_gpio_in),
        .pad_gpio_out    (pad_gpio_out),
        .pad_gpio_outenb (pad_gpio_outenb),
        .pad_gpio_cfg    (pad_gpio_cfg),
        .frame_state     (frame_state)
    );

    // clock / reset
    always #5 serial_clock = ~serial_clock;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge serial_clock)
        if (cfg_loaded === 1'b1) pulse_cnt++;

    // driver tasks
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] c1, input logic [15:0] c0);
`ifdef GPIO_CTRL_PARITY_EN
        mk = {30'b0, ^c1, c1, ^c0, c0};
`else
        mk = {32'b0, c1, c0};
`endif
    endfunction

    task automatic shift_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            serial_shift_en = 1'b1;
            serial_data_in  = w[i];
            @(negedge serial_clock);
        end
        serial_shift_en = 1'b0;
        serial_data_in  = 1'b0;
    endtask

    task automatic load_hold(input int cycles);
        serial_load = 1'b1;
        repeat (cycles) @(negedge serial_clock);
        serial_load = 1'b0;
        @(negedge serial_clock);
    endtask

    task automatic clear_err();
        frame_err_clr = 1'b1;
        @(negedge serial_clock);
        frame_err_clr = 1'b0;
    endtask

    initial begin
        @(negedge serial_clock);
        @(negedge serial_clock);
        reset = 1'b0;
        @(negedge serial_clock);

        // reset state
        check("rst_cfg", pad_gpio_cfg, 24'h600600);
        check("rst_outenb", pad_gpio_outenb, 2'b10);
        check("rst_out", pad_gpio_out, 2'b01);
        check("rst_user_in", user_gpio_in, 2'b10);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_cfg_loaded", cfg_loaded, 1'b0);
        check("rst_sdo", serial_data_out, 1'b0);
        check("rst_state", frame_state, 2'd0);
`ifdef GPIO_CTRL_PARITY_EN
        check("rst_parity_err", parity_err, 1'b0);
`endif

        // full frame, load held high for three cycles
        shift_bits(mk(16'h8007, 16'h8001), L);
        check("t2_state_full", frame_state, 2'd2);
        check("t2_sdo", serial_data_out, 1'b1);
        load_hold(3);
        check("t2_pulse", pulse_cnt, 1);
        check("t2_out", pad_gpio_out, 2'b10);
        check("t2_outenb", pad_gpio_outenb, 2'b10);
        check("t2_cfg", pad_gpio_cfg, 24'h000000);
        check("t2_frame_err", frame_err, 1'b0);
        check("t2_state_idle", frame_state, 2'd0);
        user_gpio_out = 2'b11;
        @(negedge serial_clock);
        check("t2_mgmt_override", pad_gpio_out, 2'b10);

        // short and long frames are rejected
        shift_bits(64'h0, L - 1);
        check("t3_state_fill", frame_state, 2'd1);
        load_hold(1);
        check("t3_short_err", frame_err, 1'b1);
        check("t3_short_cfg", pad_gpio_cfg, 24'h000000);
        check("t3_short_pulse", pulse_cnt, 1);
        clear_err();
        check("t3_clr", frame_err, 1'b0);
        shift_bits(64'h0, L + 1);
        check("t3_state_over", frame_state, 2'd3);
        load_hold(1);
        check("t3_long_err", frame_err, 1'b1);
        check("t3_long_out", pad_gpio_out, 2'b10);
        check("t3_long_pulse", pulse_cnt, 1);
        frame_err_clr = 1'b1;
        serial_load   = 1'b1;
        @(negedge serial_clock);
        frame_err_clr = 1'b0;
        serial_load   = 1'b0;
        @(negedge serial_clock);
        check("t3_err_wins", frame_err, 1'b1);
        clear_err();
        check("t3_clr2", frame_err, 1'b0);

        // ld_enb=0 channel keeps its config
        shift_bits(mk(16'hF000, 16'hF006), L);
        load_hold(1);
        check("t4_pre_cfg", pad_gpio_cfg, 24'hE00E00);
        check("t4_pre_out", pad_gpio_out, 2'b11);
        shift_bits(mk(16'h0007, 16'h8001), L);
        load_hold(1);
        check("t4_cfg", pad_gpio_cfg, 24'hE00000);
        check("t4_out", pad_gpio_out, 2'b10);
        check("t4_outenb", pad_gpio_outenb, 2'b10);
        check("t4_pulse", pulse_cnt, 3);

        // last bit and load edge in the same cycle
        shift_bits(64'h0, L - 1);
        serial_shift_en = 1'b1;
        serial_data_in  = 1'b1;
        serial_load     = 1'b1;
        @(negedge serial_clock);
        serial_shift_en = 1'b0;
        serial_data_in  = 1'b0;
        serial_load     = 1'b0;
        @(negedge serial_clock);
        check("t5_err", frame_err, 1'b1);
        check("t5_state_cnt1", frame_state, 2'd1);
        check("t5_cfg_kept", pad_gpio_cfg, 24'hE00000);
        check("t5_pulse", pulse_cnt, 3);
        clear_err();
        shift_bits(mk(16'h8000, 16'h8004), L - 1);
        check("t5_full_after", frame_state, 2'd2);
        load_hold(1);
        check("t5_cfg_new", pad_gpio_cfg, 24'h000000);
        check("t5_out_new", pad_gpio_out, 2'b11);
        check("t5_pulse_new", pulse_cnt, 4);

        // reset mid-shift and mid-load
        shift_bits(mk(16'h8007, 16'h8001), L);
        serial_load = 1'b1;
        reset       = 1'b1;
        @(negedge serial_clock);
        reset       = 1'b0;
        serial_load = 1'b0;
        @(negedge serial_clock);
        check("t5_rst_load_cfg", pad_gpio_cfg, 24'h600600);
        check("t5_rst_load_pulse", pulse_cnt, 4);
        shift_bits(64'hFFFF, 5);
        serial_shift_en = 1'b1;
        serial_data_in  = 1'b1;
        reset           = 1'b1;
        @(negedge serial_clock);
        reset           = 1'b0;
        serial_shift_en = 1'b0;
        serial_data_in  = 1'b0;
        @(negedge serial_clock);
        check("t5_rst_shift_state", frame_state, 2'd0);
        check("t5_rst_shift_sdo", serial_data_out, 1'b0);
        check("t5_rst_shift_cfg", pad_gpio_cfg, 24'h600600);
        check("t5_rst_shift_out", pad_gpio_out, 2'b11);

`ifdef GPIO_CTRL_PARITY_EN
        // bad parity on channel 0 only
        shift_bits({30'b0, 1'b0, 16'h8007, 1'b1, 16'h8001}, L);
        load_hold(1);
        check("t6_cfg", pad_gpio_cfg, 24'h000600);
        check("t6_out", pad_gpio_out, 2'b11);
        check("t6_outenb", pad_gpio_outenb, 2'b10);
        check("t6_parity_err", parity_err, 1'b1);
        check("t6_pulse", pulse_cnt, 4);
        check("t6_frame_err", frame_err, 1'b0);
        clear_err();
        check("t6_parity_clr", parity_err, 1'b0);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
